// File: rtl/merge_pass_scheduler_pkg.sv
// Shared types for the merge pass scheduler: FSM states, command payload and record sizing.
// Command payload fields are sized for the widest supported address/length configuration.
package merge_pass_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        NEXT_GROUP,
        NEXT_PASS,
        DONE
    } sched_state_t;

    localparam int CMD_ADDR_W = 64;
    localparam int CMD_LEN_W  = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LEN_W-1:0]  len;
    } cmd_t;

    function automatic int record_bytes(input int bit_width);
        return bit_width / 8;
    endfunction

endpackage

// File: rtl/merge_pass_scheduler_cmd_slot.sv
// Single valid/ready command holding register: loads a command and holds it
// stable until the consumer accepts it.
module cmd_slot
    import merge_pass_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_valid,
    input  cmd_t load_cmd,
    input  logic ready,
    output logic valid,
    output cmd_t cmd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            cmd   <= '0;
        end else if (load) begin
            valid <= load_valid;
            cmd   <= load_cmd;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/merge_pass_scheduler.sv
// Sequences merge-sort passes: per group it issues one read command per leaf channel
// plus one write command, then waits for the merged output to drain before moving on.
module merge_pass_scheduler
    import merge_pass_scheduler_pkg::*;
#(
    parameter int NUM_READ_CHANNELS  = 16,
    parameter int C_SORTER_BIT_WIDTH = 32,
    parameter int P                  = 4,
    parameter int ADDR_WIDTH         = 64,
    parameter int LEN_WIDTH          = 32
) (
    input  logic                                         s_axis_aclk,
    input  logic                                         s_axis_areset,
    input  logic                                         ap_start,
    output logic                                         ap_idle,
    output logic                                         ap_done,
    input  logic [ADDR_WIDTH-1:0]                        cfg_src_addr,
    input  logic [ADDR_WIDTH-1:0]                        cfg_dst_addr,
    input  logic [LEN_WIDTH-1:0]                         cfg_total_elems,
    input  logic [LEN_WIDTH-1:0]                         cfg_init_run_len,
    output logic [NUM_READ_CHANNELS-1:0]                 rd_cmd_valid,
    input  logic [NUM_READ_CHANNELS-1:0]                 rd_cmd_ready,
    output logic [NUM_READ_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [NUM_READ_CHANNELS-1:0][LEN_WIDTH-1:0]  rd_cmd_len,
    output logic                                         wr_cmd_valid,
    input  logic                                         wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0]                        wr_cmd_addr,
    output logic [LEN_WIDTH-1:0]                         wr_cmd_len,
    input  logic                                         out_beat,
    output logic [7:0]                                   pass_count,
    output logic                                         result_in_dst
);

    localparam int LOG2_CH = $clog2(NUM_READ_CHANNELS);
    localparam int EXT_W   = LEN_WIDTH + LOG2_CH;
    localparam logic [ADDR_WIDTH-1:0] REC_BYTES = ADDR_WIDTH'(record_bytes(C_SORTER_BIT_WIDTH));
    localparam logic [EXT_W-1:0]      LEN_MAX   = EXT_W'({LEN_WIDTH{1'b1}});

    sched_state_t          state_q, state_d;
    logic [LEN_WIDTH-1:0]  n_q, n_d, run_len_q, run_len_d;
    logic [EXT_W-1:0]      goff_q, goff_d, beat_q, beat_d;
    logic [EXT_W-1:0]      glen_q, beats_need_q;
    logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
    logic [7:0]            pass_q, pass_d;
    logic [EXT_W-1:0]      g_cur, g_nx, rem_nx, glen_nx, beats_nx;
    logic                  load, issue_done;
    cmd_t                  wr_ld, wr_q;

    assign g_cur      = EXT_W'(run_len_q) << LOG2_CH;
    assign issue_done = (&(~rd_cmd_valid | rd_cmd_ready)) && (!wr_cmd_valid || wr_cmd_ready);

    // Next-state and next-parameter logic; commands are built from the next values
    // so they are already valid in the first ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        run_len_d = run_len_q;
        goff_d    = goff_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        pass_d    = pass_q;
        beat_d    = beat_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    n_d       = cfg_total_elems;
                    run_len_d = cfg_init_run_len;
                    goff_d    = '0;
                    pass_d    = '0;
                    beat_d    = '0;
                    rd_base_d = cfg_src_addr;
                    wr_base_d = cfg_dst_addr;
                    state_d   = (cfg_total_elems == '0 || cfg_init_run_len >= cfg_total_elems)
                                ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (out_beat) beat_d = beat_q + 1'b1;
                if (issue_done) state_d = DRAIN;
            end
            DRAIN: begin
                if (beat_q >= beats_need_q) begin
                    beat_d  = '0;
                    state_d = NEXT_GROUP;
                end else if (out_beat) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            NEXT_GROUP: begin
                goff_d  = goff_q + glen_q;
                state_d = (goff_d < EXT_W'(n_q)) ? ISSUE : NEXT_PASS;
            end
            NEXT_PASS: begin
                pass_d    = pass_q + 8'd1;
                run_len_d = (g_cur > LEN_MAX) ? '1 : g_cur[LEN_WIDTH-1:0];
                rd_base_d = wr_base_q;
                wr_base_d = rd_base_q;
                goff_d    = '0;
                state_d   = (run_len_d >= n_q) ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            run_len_q    <= '0;
            goff_q       <= '0;
            beat_q       <= '0;
            rd_base_q    <= '0;
            wr_base_q    <= '0;
            pass_q       <= '0;
            glen_q       <= '0;
            beats_need_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            run_len_q <= run_len_d;
            goff_q    <= goff_d;
            beat_q    <= beat_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            pass_q    <= pass_d;
            if (load) begin
                glen_q       <= glen_nx;
                beats_need_q <= beats_nx;
            end
        end
    end

    assign load     = (state_d == ISSUE) && (state_q != ISSUE);
    assign g_nx     = EXT_W'(run_len_d) << LOG2_CH;
    assign rem_nx   = EXT_W'(n_d) - goff_d;
    assign glen_nx  = (g_nx < rem_nx) ? g_nx : rem_nx;
    assign beats_nx = (glen_nx + EXT_W'(P - 1)) / EXT_W'(P);

    for (genvar k = 0; k < NUM_READ_CHANNELS; k++) begin : g_rd
        logic [EXT_W-1:0] off, rem, len;
        cmd_t             ld, q;

        assign off     = goff_d + EXT_W'(k) * EXT_W'(run_len_d);
        assign rem     = (off < EXT_W'(n_d)) ? EXT_W'(n_d) - off : '0;
        assign len     = (rem < EXT_W'(run_len_d)) ? rem : EXT_W'(run_len_d);
        assign ld.addr = CMD_ADDR_W'(rd_base_d + ADDR_WIDTH'(off) * REC_BYTES);
        assign ld.len  = CMD_LEN_W'(len);

        cmd_slot u_rd_slot (
            .clk        (s_axis_aclk),
            .rst        (s_axis_areset),
            .load       (load),
            .load_valid (len != '0),
            .load_cmd   (ld),
            .ready      (rd_cmd_ready[k]),
            .valid      (rd_cmd_valid[k]),
            .cmd        (q)
        );

        assign rd_cmd_addr[k] = ADDR_WIDTH'(q.addr);
        assign rd_cmd_len[k]  = LEN_WIDTH'(q.len);
    end

    assign wr_ld.addr = CMD_ADDR_W'(wr_base_d + ADDR_WIDTH'(goff_d) * REC_BYTES);
    assign wr_ld.len  = CMD_LEN_W'(glen_nx);

    cmd_slot u_wr_slot (
        .clk        (s_axis_aclk),
        .rst        (s_axis_areset),
        .load       (load),
        .load_valid (1'b1),
        .load_cmd   (wr_ld),
        .ready      (wr_cmd_ready),
        .valid      (wr_cmd_valid),
        .cmd        (wr_q)
    );

    assign wr_cmd_addr   = ADDR_WIDTH'(wr_q.addr);
    assign wr_cmd_len    = LEN_WIDTH'(wr_q.len);
    assign ap_idle       = (state_q == IDLE);
    assign ap_done       = (state_q == DONE);
    assign pass_count    = pass_q;
    assign result_in_dst = pass_q[0];

endmodule
